// File: rtl/ff_pkg.sv
// Shared constants and types for the limb-serial GF(p) arithmetic blocks.
package ff_pkg;

  localparam logic [255:0] P25519 =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  typedef enum logic {
    FF_ADD = 1'b0,
    FF_SUB = 1'b1
  } ff_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL
  } ff_state_e;

  // One spare bit above WIDTH so that a + b never overflows the internal width.
  function automatic int ff_nlimb(input int width, input int limb);
    return (width + limb) / limb;
  endfunction

  function automatic int ff_w1(input int width, input int limb);
    return ff_nlimb(width, limb) * limb;
  endfunction

endpackage

// File: rtl/ff_limb_addsub.sv
// One LIMB-wide add/subtract slice; cout is the carry when adding and the borrow when subtracting.
module ff_limb_addsub
  import ff_pkg::*;
#(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] x,
  input  logic [LIMB-1:0] y,
  input  logic            sub,
  input  logic            cin,
  output logic [LIMB-1:0] s,
  output logic            cout
);

  logic [LIMB:0] res;

  always_comb begin
    res = '0;
    if (sub) begin
      res = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, cin};
    end else begin
      res = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
    end
    s    = res[LIMB-1:0];
    cout = res[LIMB];
  end

endmodule

// File: rtl/ff_addsub_serial.sv
// Limb-serial modular add/sub over GF(p): out = (a op b) mod P, with a lagging correction pass.
// Optional operand range check (range_err port) is compiled in with FF_ADDSUB_RANGE_CHECK_EN.
module ff_addsub_serial
  import ff_pkg::*;
#(
  parameter int WIDTH = 255,
  parameter int LIMB  = 64,
  parameter logic [ff_w1(WIDTH, LIMB)-1:0] P = P25519
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef FF_ADDSUB_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  localparam int NLIMB = ff_nlimb(WIDTH, LIMB);
  localparam int W1    = NLIMB * LIMB;
  localparam int CW    = $clog2(NLIMB + 1);
  localparam int NTAB  = 2 ** CW;

  ff_state_e state_q, state_d;
  ff_op_e    op_q, op_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W1-1:0]    a_q, a_d;
  logic [W1-1:0]    b_q, b_d;
  logic [W1-1:0]    r_q, r_d;
  logic [W1-1:0]    t_q, t_d;
  logic             c1_q, c1_d;
  logic             c2_q, c2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic [LIMB-1:0] s1, s2;
  logic            co1, co2;
  logic [CW-1:0]   lag_idx;
  logic [W1-1:0]   t_full;
  logic [W1-1:0]   sel;
  logic            sel_unused;

  // Modulus limbs, padded with zeros so any counter value is a legal index.
  logic [LIMB-1:0] p_limbs [NTAB];

  for (genvar i = 0; i < NTAB; i++) begin : g_p
    if (i < NLIMB) begin : g_real
      assign p_limbs[i] = P[i*LIMB +: LIMB];
    end else begin : g_pad
      assign p_limbs[i] = '0;
    end
  end

  assign lag_idx = cnt_q - CW'(1);

  ff_limb_addsub #(.LIMB(LIMB)) u_pass1 (
    .x    (a_q[LIMB-1:0]),
    .y    (b_q[LIMB-1:0]),
    .sub  (op_q == FF_SUB),
    .cin  (c1_q),
    .s    (s1),
    .cout (co1)
  );

  // Correction runs one limb behind pass 1, reading the limb it just produced.
  ff_limb_addsub #(.LIMB(LIMB)) u_corr (
    .x    (r_q[W1-1 -: LIMB]),
    .y    (p_limbs[lag_idx]),
    .sub  (op_q == FF_ADD),
    .cin  (c2_q),
    .s    (s2),
    .cout (co2)
  );

  assign t_full = {s2, t_q[W1-1:LIMB]};

  always_comb begin
    sel = r_q;
    if (op_q == FF_ADD) begin
      sel = co2 ? r_q : t_full;
    end else begin
      sel = c1_q ? t_full : r_q;
    end
  end

  assign sel_unused = ^sel[W1-1:WIDTH];

`ifdef FF_ADDSUB_RANGE_CHECK_EN
  logic            ca_q, ca_d;
  logic            cb_q, cb_d;
  logic            rerr_q, rerr_d;
  logic [LIMB-1:0] sa_unused, sb_unused;
  logic            coa, cob;

  ff_limb_addsub #(.LIMB(LIMB)) u_range_a (
    .x    (a_q[LIMB-1:0]),
    .y    (p_limbs[cnt_q]),
    .sub  (1'b1),
    .cin  (ca_q),
    .s    (sa_unused),
    .cout (coa)
  );

  ff_limb_addsub #(.LIMB(LIMB)) u_range_b (
    .x    (b_q[LIMB-1:0]),
    .y    (p_limbs[cnt_q]),
    .sub  (1'b1),
    .cin  (cb_q),
    .s    (sb_unused),
    .cout (cob)
  );

  always_comb begin
    ca_d   = ca_q;
    cb_d   = cb_q;
    rerr_d = rerr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ca_d = 1'b0;
          cb_d = 1'b0;
        end
      end
      RUN: begin
        ca_d = coa;
        cb_d = cob;
      end
      FINAL: begin
        rerr_d = ~ca_q | ~cb_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca_q   <= 1'b0;
      cb_q   <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      ca_q   <= ca_d;
      cb_q   <= cb_d;
      rerr_q <= rerr_d;
    end
  end

  assign range_err = rerr_q;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    t_d     = t_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          op_d    = ff_op_e'(op);
          a_d     = W1'(a);
          b_d     = W1'(b);
          r_d     = '0;
          t_d     = '0;
          c1_d    = 1'b0;
          c2_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> LIMB;
        b_d   = b_q >> LIMB;
        r_d   = {s1, r_q[W1-1:LIMB]};
        c1_d  = co1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q != '0) begin
          t_d  = t_full;
          c2_d = co2;
        end
        if (cnt_q == CW'(NLIMB - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        out_d   = sel[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= FF_ADD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      t_q     <= t_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_ff_addsub_serial.sv
// Directed bench for ff_addsub_serial: a 64-bit-limb and a 32-bit-limb instance driven in parallel.
module tb_ff_addsub_serial;

  localparam logic [255:0] PMOD =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [254:0] PM1 = PMOD[254:0] - 255'd1;
  localparam logic [254:0] PM2 = PMOD[254:0] - 255'd2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [254:0] a;
  logic [254:0] b;
  logic         busy64, done64, busy32, done32;
  logic [254:0] out64, out32;
`ifdef FF_ADDSUB_RANGE_CHECK_EN
  logic         rerr64, rerr32;
  logic         lastRange64;
`endif

  int total;
  int bad;

  ff_addsub_serial #(.WIDTH(255), .LIMB(64)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy64),
    .done  (done64),
    .out   (out64)
`ifdef FF_ADDSUB_RANGE_CHECK_EN
    ,
    .range_err (rerr64)
`endif
  );

  ff_addsub_serial #(.WIDTH(255), .LIMB(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy32),
    .done  (done32),
    .out   (out32)
`ifdef FF_ADDSUB_RANGE_CHECK_EN
    ,
    .range_err (rerr32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one op and watch both instances for 12 cycles after the accepting edge.
  task automatic applyStimulus(input string tag, input logic [254:0] av,
                               input logic [254:0] bv, input logic opv,
                               input logic [254:0] expv, input bit chkOut);
    int doneAt64, doneCnt64, busyMis64, doneAt32, doneCnt32, busyMis32;
    logic [254:0] seen64, seen32;
    doneAt64 = 0; doneCnt64 = 0; busyMis64 = 0;
    doneAt32 = 0; doneCnt32 = 0; busyMis32 = 0;
    seen64 = '0; seen32 = '0;
    a = av; b = bv; op = opv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; op = ~opv;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (done64) begin
        if (doneAt64 == 0) doneAt64 = c;
        doneCnt64++;
        seen64 = out64;
`ifdef FF_ADDSUB_RANGE_CHECK_EN
        lastRange64 = rerr64;
`endif
      end
      if (done32) begin
        if (doneAt32 == 0) doneAt32 = c;
        doneCnt32++;
        seen32 = out32;
      end
      if (busy64 !== 1'(c <= 5)) busyMis64++;
      if (busy32 !== 1'(c <= 9)) busyMis32++;
    end
    checkOutput({tag, "/done_cycle64"}, 256'(doneAt64), 256'd6);
    checkOutput({tag, "/done_count64"}, 256'(doneCnt64), 256'd1);
    checkOutput({tag, "/busy64"}, 256'(busyMis64), 256'd0);
    checkOutput({tag, "/done_cycle32"}, 256'(doneAt32), 256'd10);
    checkOutput({tag, "/done_count32"}, 256'(doneCnt32), 256'd1);
    checkOutput({tag, "/busy32"}, 256'(busyMis32), 256'd0);
    if (chkOut) begin
      checkOutput({tag, "/out64"}, 256'(seen64), 256'(expv));
      checkOutput({tag, "/out32"}, 256'(seen32), 256'(expv));
    end
  endtask

  initial begin
    int n;
    int bbCycle [4];
    logic [254:0] bbOut [4];
    logic [254:0] bbOut32;
    int overlap;
    int doneAfterRst;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
`ifdef FF_ADDSUB_RANGE_CHECK_EN
    lastRange64 = 1'b1;
`endif

    $display("[TB] reset state");
    #12;
    checkOutput("rst/out64", 256'(out64), 256'd0);
    checkOutput("rst/busy64", 256'(busy64), 256'd0);
    checkOutput("rst/done64", 256'(done64), 256'd0);
    checkOutput("rst/out32", 256'(out32), 256'd0);
`ifdef FF_ADDSUB_RANGE_CHECK_EN
    checkOutput("rst/range_err64", 256'(rerr64), 256'd0);
`endif
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    applyStimulus("add_5_7", 255'd5, 255'd7, 1'b0, 255'd12, 1'b1);
`ifdef FF_ADDSUB_RANGE_CHECK_EN
    checkOutput("add_5_7/range_err", 256'(lastRange64), 256'd0);
`endif
    applyStimulus("add_pm1_2", PM1, 255'd2, 1'b0, 255'd1, 1'b1);
    applyStimulus("add_pm1_1", PM1, 255'd1, 1'b0, 255'd0, 1'b1);
    applyStimulus("add_pm1_pm1", PM1, PM1, 1'b0, PM2, 1'b1);
    applyStimulus("sub_3_5", 255'd3, 255'd5, 1'b1, PM2, 1'b1);
    applyStimulus("sub_0_0", 255'd0, 255'd0, 1'b1, 255'd0, 1'b1);
    applyStimulus("sub_pm1_0", PM1, 255'd0, 1'b1, PM1, 1'b1);

    $display("[TB] back-to-back with start held high");
    n = 0;
    overlap = 0;
    bbOut32 = '0;
    for (int c = 0; c < 18; c++) begin
      a = 255'(100 + c);
      b = 255'(c);
      op = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      if (busy64 && done64) overlap++;
      if (done64 && n < 4) begin
        bbCycle[n] = c + 1;
        bbOut[n] = out64;
        n++;
      end
      if (done32 && (c + 1) == 10) bbOut32 = out32;
    end
    start = 1'b0;
    checkOutput("b2b/count", 256'(n), 256'd3);
    checkOutput("b2b/overlap", 256'(overlap), 256'd0);
    checkOutput("b2b/cycle0", 256'(bbCycle[0]), 256'd6);
    checkOutput("b2b/out0", 256'(bbOut[0]), 256'd100);
    checkOutput("b2b/cycle1", 256'(bbCycle[1]), 256'd12);
    checkOutput("b2b/out1", 256'(bbOut[1]), 256'd112);
    checkOutput("b2b/cycle2", 256'(bbCycle[2]), 256'd18);
    checkOutput("b2b/out2", 256'(bbOut[2]), 256'd124);
    checkOutput("b2b/out32_first", 256'(bbOut32), 256'd100);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("b2b/out32_second", 256'(out32), 256'd120);

    $display("[TB] reset abort mid-operation");
    applyStimulus("pre_rst", PM1, 255'd0, 1'b1, PM1, 1'b1);
    a = 255'd5; b = 255'd7; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort/out64", 256'(out64), 256'd0);
    checkOutput("abort/busy64", 256'(busy64), 256'd0);
    checkOutput("abort/out32", 256'(out32), 256'd0);
    #2 rst_n = 1'b1;
    doneAfterRst = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done64 || done32) doneAfterRst++;
    end
    checkOutput("abort/no_done", 256'(doneAfterRst), 256'd0);
    checkOutput("abort/out64_held", 256'(out64), 256'd0);
    applyStimulus("after_rst", 255'd5, 255'd7, 1'b0, 255'd12, 1'b1);

`ifdef FF_ADDSUB_RANGE_CHECK_EN
    $display("[TB] range check");
    applyStimulus("range_a_eq_p", PMOD[254:0], 255'd0, 1'b0, 255'd0, 1'b0);
    checkOutput("range_a_eq_p/range_err", 256'(lastRange64), 256'd1);
    applyStimulus("range_ok", PM1, PM1, 1'b0, PM2, 1'b1);
    checkOutput("range_ok/range_err", 256'(lastRange64), 256'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
